// File: rtl/repl_pkg.sv
// repl_pkg: replacement policy modes and maximal-length LFSR tap masks
package repl_pkg;
  typedef enum logic [1:0] {
    REPL_RAND = 2'd0,
    REPL_NMRU = 2'd1,
    REPL_PLRU = 2'd2
  } repl_mode_e;
  // Bit i of the mask set means state[i] feeds the XOR; widths outside 4..16 fall back to 16
  function automatic logic [15:0] lfsr_taps(input int width);
    return width == 4  ? 16'h000C :
           width == 5  ? 16'h0014 :
           width == 6  ? 16'h0030 :
           width == 7  ? 16'h0060 :
           width == 8  ? 16'h00B8 :
           width == 9  ? 16'h0110 :
           width == 10 ? 16'h0240 :
           width == 11 ? 16'h0500 :
           width == 12 ? 16'h0829 :
           width == 13 ? 16'h100D :
           width == 14 ? 16'h2015 :
           width == 15 ? 16'h6000 : 16'hD008;
  endfunction
endpackage

// File: rtl/galois_free_lfsr.sv
// galois_free_lfsr: Fibonacci shift-left LFSR with seed load; a zero seed loads 1
module galois_free_lfsr
  import repl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);
  localparam logic [15:0] TAPS = lfsr_taps(WIDTH);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WIDTH'(1);
    else if (load) state <= seed == '0 ? WIDTH'(1) : seed;
    else if (enable) state <= {state[WIDTH-2:0], ^(state & TAPS[WIDTH-1:0])};
  end
endmodule

// File: rtl/repl_way_select.sv
// repl_way_select: per-set victim way selection (random, not-MRU, tree pseudo-LRU)
module repl_way_select
  import repl_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 16,
  parameter int LFSR_BITS = 8,
  localparam int WAY_BITS = $clog2(NUM_WAYS),
  localparam int SET_BITS = $clog2(NUM_SETS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 access_valid,
  input  logic [SET_BITS-1:0]  access_set,
  input  logic [WAY_BITS-1:0]  access_way,
  input  logic                 query_valid,
  input  logic [SET_BITS-1:0]  query_set,
  input  logic [NUM_WAYS-1:0]  way_valid,
  input  logic                 seed_load,
  input  logic [LFSR_BITS-1:0] seed,
  output logic                 victim_valid,
  output logic [WAY_BITS-1:0]  victim_way
);
  logic [LFSR_BITS-1:0] lfsr;
  logic [WAY_BITS-1:0]  mru [NUM_SETS];
  logic [NUM_WAYS-2:0]  plru [NUM_SETS];
  logic [WAY_BITS-1:0]  rand_way, nmru_way, plru_way, invalid_way, pick;
  logic                 unused_lfsr;
  // Tree nodes are heap-ordered: node n has children 2n+1 (lower ways) and 2n+2
  function automatic logic [WAY_BITS-1:0] plru_pick(input logic [NUM_WAYS-2:0] tree);
    logic [WAY_BITS-1:0] node, way;
    node = '0;
    way = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      way = (way << 1) | WAY_BITS'(tree[node]);
      node = (node << 1) + WAY_BITS'(1) + WAY_BITS'(tree[node]);
    end
    return way;
  endfunction
  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] tree,
                                                     input logic [WAY_BITS-1:0] way);
    logic [WAY_BITS-1:0] node, path;
    logic b;
    node = '0;
    path = way;
    for (int l = 0; l < WAY_BITS; l++) begin
      b = path[WAY_BITS-1];
      tree[node] = ~b;
      node = (node << 1) + WAY_BITS'(1) + WAY_BITS'(b);
      path = path << 1;
    end
    return tree;
  endfunction
  galois_free_lfsr #(.WIDTH(LFSR_BITS)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .enable(query_valid),
    .load  (seed_load),
    .seed  (seed),
    .state (lfsr)
  );
  assign unused_lfsr = ^lfsr[LFSR_BITS-1:WAY_BITS];
  always_comb begin
    invalid_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (!way_valid[i]) invalid_way = WAY_BITS'(i);
  end
  // Reserved mode 3 falls through to random
  always_comb begin
    rand_way = lfsr[WAY_BITS-1:0];
    nmru_way = rand_way != mru[query_set] ? rand_way : mru[query_set] + WAY_BITS'(1);
    plru_way = plru_pick(plru[query_set]);
    pick = ~&way_valid ? invalid_way :
           mode == REPL_NMRU ? nmru_way :
           mode == REPL_PLRU ? plru_way : rand_way;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      victim_valid <= 1'b0;
      victim_way <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        mru[s] <= '0;
        plru[s] <= '0;
      end
    end else begin
      victim_valid <= query_valid;
      if (query_valid) victim_way <= pick;
      if (access_valid) begin
        mru[access_set] <= access_way;
        plru[access_set] <= plru_touch(plru[access_set], access_way);
      end
    end
  end
endmodule

// File: tb/tb_repl_way_select.sv
// tb_repl_way_select: scenario tasks with a queue of expected victims
module tb_repl_way_select;
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       access_valid;
  logic [3:0] access_set;
  logic [1:0] access_way;
  logic       query_valid;
  logic [3:0] query_set;
  logic [3:0] way_valid;
  logic       seed_load;
  logic [7:0] seed;
  logic       victim_valid;
  logic [1:0] victim_way;
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  repl_way_select #(.NUM_WAYS(4), .NUM_SETS(16), .LFSR_BITS(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .access_valid(access_valid),
    .access_set  (access_set),
    .access_way  (access_way),
    .query_valid (query_valid),
    .query_set   (query_set),
    .way_valid   (way_valid),
    .seed_load   (seed_load),
    .seed        (seed),
    .victim_valid(victim_valid),
    .victim_way  (victim_way)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    mode = 2'd0;
    access_valid = 1'b0;
    access_set = '0;
    access_way = '0;
    query_valid = 1'b0;
    query_set = '0;
    way_valid = 4'hF;
    seed_load = 1'b0;
    seed = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (victim_valid !== 1'b0 || victim_way !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b way=%0d, want valid=0 way=0", victim_valid, victim_way);
    end
    do_reset();
    checks++;
    if (victim_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got valid=%b, want 0", victim_valid);
    end
  endtask

  task automatic test_rand_back_to_back();
    logic [1:0] ex[3];
    logic [1:0] e;
    ex = '{2'd1, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      query_valid = 1'b1;
      exp_q.push_back(ex[i]);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (victim_valid !== 1'b1 || victim_way !== e) begin
        errors++;
        $display("FAIL rand_b2b[%0d]: got valid=%b way=%0d, want valid=1 way=%0d", i, victim_valid, victim_way, e);
      end
    end
    query_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (victim_valid !== 1'b0 || victim_way !== 2'd0) begin
      errors++;
      $display("FAIL rand_b2b_hold: got valid=%b way=%0d, want valid=0 way=0", victim_valid, victim_way);
    end
  endtask

  task automatic test_plru();
    int acc[3];
    logic [1:0] ex[3];
    logic [1:0] e;
    acc = '{-1, 0, 2};
    ex = '{2'd0, 2'd2, 2'd1};
    do_reset();
    mode = 2'd2;
    query_set = 4'd3;
    access_set = 4'd3;
    for (int i = 0; i < 3; i++) begin
      if (acc[i] >= 0) begin
        access_valid = 1'b1;
        access_way = 2'(acc[i]);
        @(negedge clock);
        access_valid = 1'b0;
      end
      query_valid = 1'b1;
      exp_q.push_back(ex[i]);
      @(negedge clock);
      query_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (victim_valid !== 1'b1 || victim_way !== e) begin
        errors++;
        $display("FAIL plru[%0d]: got valid=%b way=%0d, want valid=1 way=%0d", i, victim_valid, victim_way, e);
      end
    end
  endtask

  task automatic test_nmru();
    logic [3:0] st[3];
    logic [1:0] ex[3];
    logic [1:0] e;
    // Access and query to set 5 together: query must see mru=0, not the new mru=1
    do_reset();
    mode = 2'd1;
    query_set = 4'd5;
    access_set = 4'd5;
    access_way = 2'd1;
    access_valid = 1'b1;
    query_valid = 1'b1;
    exp_q.push_back(2'd1);
    @(negedge clock);
    access_valid = 1'b0;
    exp_q.push_back(2'd2);
    e = exp_q.pop_front();
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== e) begin
      errors++;
      $display("FAIL nmru_same_cycle: got valid=%b way=%0d, want valid=1 way=%0d", victim_valid, victim_way, e);
    end
    @(negedge clock);
    query_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== e) begin
      errors++;
      $display("FAIL nmru_after_update: got valid=%b way=%0d, want valid=1 way=%0d", victim_valid, victim_way, e);
    end
    st = '{4'd5, 4'd5, 4'd6};
    ex = '{2'd2, 2'd2, 2'd1};
    do_reset();
    mode = 2'd1;
    access_set = 4'd5;
    access_way = 2'd1;
    access_valid = 1'b1;
    @(negedge clock);
    access_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      query_set = st[i];
      query_valid = 1'b1;
      exp_q.push_back(ex[i]);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (victim_valid !== 1'b1 || victim_way !== e) begin
        errors++;
        $display("FAIL nmru[%0d]: got valid=%b way=%0d, want valid=1 way=%0d", i, victim_valid, victim_way, e);
      end
    end
    query_valid = 1'b0;
  endtask

  task automatic test_invalid_ways();
    logic [1:0] md[6];
    logic [3:0] wv[6];
    logic [1:0] ex[6];
    logic [1:0] e;
    md = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
    wv = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b1101};
    ex = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mode = md[i];
      way_valid = wv[i];
      query_valid = 1'b1;
      exp_q.push_back(ex[i]);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (victim_valid !== 1'b1 || victim_way !== e) begin
        errors++;
        $display("FAIL invalid[%0d]: got valid=%b way=%0d, want valid=1 way=%0d", i, victim_valid, victim_way, e);
      end
    end
    query_valid = 1'b0;
    way_valid = 4'hF;
  endtask

  task automatic test_seed();
    logic [1:0] ex[6];
    logic       ld[6];
    logic       qv[6];
    logic [7:0] sd[6];
    logic [1:0] e;
    // LFSR 1 -> 2, load 0 (gives 1), query, load 3, query, then load+query in one cycle
    ld = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    qv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    sd = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h0A};
    ex = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd3, 2'd2};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      seed_load = ld[i];
      seed = sd[i];
      query_valid = qv[i];
      if (qv[i]) exp_q.push_back(ex[i]);
      @(negedge clock);
      if (qv[i]) begin
        e = exp_q.pop_front();
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== e) begin
          errors++;
          $display("FAIL seed[%0d]: got valid=%b way=%0d, want valid=1 way=%0d", i, victim_valid, victim_way, e);
        end
      end
    end
    seed_load = 1'b0;
    query_valid = 1'b1;
    exp_q.push_back(2'd2);
    @(negedge clock);
    query_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== e) begin
      errors++;
      $display("FAIL seed_priority: got valid=%b way=%0d, want valid=1 way=%0d", victim_valid, victim_way, e);
    end
  endtask

  task automatic test_mode_retained();
    logic [3:0] st[2];
    logic [1:0] ex[2];
    logic [1:0] e;
    st = '{4'd7, 4'd3};
    ex = '{2'd2, 2'd0};
    do_reset();
    mode = 2'd0;
    access_set = 4'd7;
    access_way = 2'd0;
    access_valid = 1'b1;
    @(negedge clock);
    access_valid = 1'b0;
    mode = 2'd2;
    for (int i = 0; i < 2; i++) begin
      query_set = st[i];
      query_valid = 1'b1;
      exp_q.push_back(ex[i]);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (victim_valid !== 1'b1 || victim_way !== e) begin
        errors++;
        $display("FAIL mode_retained[%0d]: got valid=%b way=%0d, want valid=1 way=%0d", i, victim_valid, victim_way, e);
      end
    end
    query_valid = 1'b0;
  endtask

  task automatic test_rand_stream();
    logic [7:0] model;
    logic [1:0] last;
    logic [1:0] e;
    logic       qv;
    do_reset();
    model = 8'h01;
    last = 2'd0;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 1) != 0 ? 2'd3 : 2'd0;
      qv = $urandom_range(0, 3) != 0;
      query_valid = qv;
      query_set = 4'($urandom_range(0, 15));
      access_valid = 1'($urandom_range(0, 1));
      access_set = 4'($urandom_range(0, 15));
      access_way = 2'($urandom_range(0, 3));
      if (qv) begin
        exp_q.push_back(model[1:0]);
        model = {model[6:0], model[7] ^ model[5] ^ model[4] ^ model[3]};
      end
      @(negedge clock);
      if (qv) begin
        e = exp_q.pop_front();
        last = e;
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== e) begin
          errors++;
          $display("FAIL rand_stream[%0d]: got valid=%b way=%0d, want valid=1 way=%0d", i, victim_valid, victim_way, e);
        end
      end else begin
        checks++;
        if (victim_valid !== 1'b0 || victim_way !== last) begin
          errors++;
          $display("FAIL rand_stream_hold[%0d]: got valid=%b way=%0d, want valid=0 way=%0d", i, victim_valid, victim_way, last);
        end
      end
    end
    query_valid = 1'b0;
    access_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [1:0] e;
    do_reset();
    query_valid = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b1;
    query_valid = 1'b0;
    #1;
    checks++;
    if (victim_valid !== 1'b0 || victim_way !== 2'd0) begin
      errors++;
      $display("FAIL reset_midflight: got valid=%b way=%0d, want valid=0 way=0", victim_valid, victim_way);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (victim_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_dropped: got valid=%b, want 0", victim_valid);
    end
    query_valid = 1'b1;
    exp_q.push_back(2'd1);
    @(negedge clock);
    query_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== e) begin
      errors++;
      $display("FAIL reset_next_query: got valid=%b way=%0d, want valid=1 way=%0d", victim_valid, victim_way, e);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rand_back_to_back();
    test_plru();
    test_nmru();
    test_invalid_ways();
    test_seed();
    test_mode_retained();
    test_rand_stream();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
